// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: WB wins at 0 latency; MC results queue in an in-order FIFO and drain on idle WB slots.
// mc_ready drops only when the FIFO is full; a queued entry's register stays flagged in pending until it is written.
module regfile_write_arbiter #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wb_valid,
    input  logic [ADDRESS_WIDTH-1:0]        wb_rd,
    input  logic [DATA_WIDTH-1:0]           wb_data,
    input  logic                            mc_valid,
    output logic                            mc_ready,
    input  logic [ADDRESS_WIDTH-1:0]        mc_rd,
    input  logic [DATA_WIDTH-1:0]           mc_data,
    output logic                            WE3,
    output logic [ADDRESS_WIDTH-1:0]        AD3,
    output logic [DATA_WIDTH-1:0]           WD3,
    output logic [(1<<ADDRESS_WIDTH)-1:0]   pending,
    output logic [$clog2(DEPTH):0]          fifo_count,
    output logic                            wb_conflict
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDRESS_WIDTH-1:0] r_rd   [DEPTH];
    logic [DATA_WIDTH-1:0]    r_data [DEPTH];
    logic [PW-1:0]            r_wptr;
    logic [PW-1:0]            r_rptr;
    logic [CW-1:0]            r_count;

    logic w_empty;
    logic w_push;
    logic w_pop;
    logic [PW-1:0] w_off;

    assign w_empty    = (r_count == '0);
    assign mc_ready   = (r_count < CW'(DEPTH));
    assign fifo_count = r_count;
    assign w_push     = mc_valid && mc_ready && (mc_rd != '0);
    // Any WB slot, even one targeting x0, blocks the drain.
    assign w_pop      = !rst && !wb_valid && !w_empty;

    always_comb begin
        WE3 = 1'b0;
        AD3 = wb_rd;
        WD3 = wb_data;
        if (wb_valid) begin
            WE3 = (wb_rd != '0);
        end else if (!w_empty) begin
            WE3 = 1'b1;
            AD3 = r_rd[r_rptr];
            WD3 = r_data[r_rptr];
        end
        if (rst) begin
            WE3 = 1'b0;
        end
    end

    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin
        pending = '0;
        w_off   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off = PW'(i) - r_rptr;
            if ({1'b0, w_off} < r_count) begin
                pending[r_rd[i]] = 1'b1;
            end
        end
        pending[0] = 1'b0;
    end

    assign wb_conflict = wb_valid && (wb_rd != '0) && pending[wb_rd];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_rd[r_wptr]   <= mc_rd;
            r_data[r_wptr] <= mc_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: inputs change 1 time unit after each rising edge, outputs checked 1 unit later.
module tb_regfile_write_arbiter;
    logic        clk;
    logic        rst;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mc_valid;
    logic        mc_ready;
    logic [4:0]  mc_rd;
    logic [31:0] mc_data;
    logic        WE3;
    logic [4:0]  AD3;
    logic [31:0] WD3;
    logic [31:0] pending;
    logic [2:0]  fifo_count;
    logic        wb_conflict;

    int checks   = 0;
    int failures = 0;

    regfile_write_arbiter #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_rd(mc_rd), .mc_data(mc_data),
        .WE3(WE3), .AD3(AD3), .WD3(WD3),
        .pending(pending), .fifo_count(fifo_count), .wb_conflict(wb_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        mc_valid = 1'b0; mc_rd = '0; mc_data = '0;
        repeat (2) @(posedge clk);
        #1;
        // WE3 masked while reset is high, even with a WB write presented
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234;
        #1 chk("rst_we3_masked", WE3, 0);
        chk("rst_mc_ready", mc_ready, 1);
        chk("rst_count", fifo_count, 0);
        rst = 1'b0;
        #1 chk("wb_we3", WE3, 1);
        chk("wb_ad3", AD3, 5);
        chk("wb_wd3", WD3, 32'h1234);
        chk("wb_pending", pending, 0);
        chk("wb_count", fifo_count, 0);

        // Single MC push, written the cycle after acceptance
        tick();
        wb_valid = 1'b0; mc_valid = 1'b1; mc_rd = 5'd7; mc_data = 32'hAA;
        #1 chk("mc1_ready", mc_ready, 1);
        chk("mc1_we3_before", WE3, 0);
        tick();
        mc_valid = 1'b0;
        #1 chk("mc1_we3", WE3, 1);
        chk("mc1_ad3", AD3, 7);
        chk("mc1_wd3", WD3, 32'hAA);
        chk("mc1_pending", pending, 32'h80);
        chk("mc1_count", fifo_count, 1);
        tick();
        #1 chk("mc1_pending_clr", pending, 0);
        chk("mc1_count_clr", fifo_count, 0);
        chk("mc1_we3_idle", WE3, 0);

        // Priority: WB holds the port for 3 cycles while (3,0x11) waits
        mc_valid = 1'b1; mc_rd = 5'd3; mc_data = 32'h11;
        tick();
        mc_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h22;
        for (int k = 0; k < 3; k++) begin
            #1 chk("prio_wb_ad3", AD3, 4);
            chk("prio_wb_wd3", WD3, 32'h22);
            chk("prio_count", fifo_count, 1);
            chk("prio_pending", pending, 32'h8);
            tick();
        end
        wb_valid = 1'b0;
        #1 chk("prio_drain_we3", WE3, 1);
        chk("prio_drain_ad3", AD3, 3);
        chk("prio_drain_wd3", WD3, 32'h11);
        tick();
        #1 chk("prio_count_clr", fifo_count, 0);

        // Fill under WB traffic, back-pressure, then drain across the pointer wrap
        wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h22;
        for (int k = 0; k < 4; k++) begin
            mc_valid = 1'b1; mc_rd = 5'(10 + k); mc_data = 32'(32'h100 + k);
            #1 chk("fill_ready", mc_ready, 1);
            tick();
        end
        mc_rd = 5'd20; mc_data = 32'h200;
        #1 chk("full_count", fifo_count, 4);
        chk("full_ready", mc_ready, 0);
        chk("full_pending", pending, 32'h3C00);
        chk("full_wb_ad3", AD3, 4);
        tick();
        #1 chk("full_5th_rejected", fifo_count, 4);
        mc_valid = 1'b0; wb_valid = 1'b0;
        #1 chk("drain0_ad3", AD3, 10);
        chk("drain0_wd3", WD3, 32'h100);
        chk("drain0_ready", mc_ready, 0);
        tick();
        mc_valid = 1'b1; mc_rd = 5'd14; mc_data = 32'h104;
        #1 chk("drain1_ad3", AD3, 11);
        chk("drain1_wd3", WD3, 32'h101);
        chk("drain1_ready", mc_ready, 1);
        chk("drain1_count", fifo_count, 3);
        tick();
        mc_valid = 1'b0;
        #1 chk("drain2_ad3", AD3, 12);
        chk("pushpop_count", fifo_count, 3);
        tick();
        #1 chk("drain3_ad3", AD3, 13);
        chk("drain3_wd3", WD3, 32'h103);
        chk("drain3_count", fifo_count, 2);
        tick();
        #1 chk("wrap_ad3", AD3, 14);
        chk("wrap_wd3", WD3, 32'h104);
        chk("wrap_pending", pending, 32'h4000);
        tick();
        #1 chk("wrap_empty_count", fifo_count, 0);
        chk("wrap_empty_we3", WE3, 0);

        // x0: MC to r0 is swallowed; WB to r0 blocks the drain without writing
        mc_valid = 1'b1; mc_rd = 5'd0; mc_data = 32'h55;
        #1 chk("x0_mc_ready", mc_ready, 1);
        tick();
        mc_valid = 1'b0;
        #1 chk("x0_mc_count", fifo_count, 0);
        chk("x0_mc_we3", WE3, 0);
        mc_valid = 1'b1; mc_rd = 5'd6; mc_data = 32'h66;
        tick();
        mc_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h77;
        #1 chk("x0_wb_we3", WE3, 0);
        chk("x0_wb_count", fifo_count, 1);
        tick();
        #1 chk("x0_wb_no_drain", fifo_count, 1);
        wb_valid = 1'b0;
        #1 chk("x0_drain_ad3", AD3, 6);
        chk("x0_drain_wd3", WD3, 32'h66);
        tick();
        #1 chk("x0_count_clr", fifo_count, 0);

        // Conflict flag, then reset with 3 entries queued
        mc_valid = 1'b1; mc_rd = 5'd9; mc_data = 32'h99;
        tick();
        wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h77; mc_rd = 5'd15; mc_data = 32'h15;
        #1 chk("conflict_flag", wb_conflict, 1);
        chk("conflict_we3", WE3, 1);
        chk("conflict_ad3", AD3, 9);
        chk("conflict_wd3", WD3, 32'h77);
        tick();
        wb_rd = 5'd8; mc_rd = 5'd16; mc_data = 32'h16;
        #1 chk("no_conflict", wb_conflict, 0);
        chk("conflict_count2", fifo_count, 2);
        tick();
        mc_valid = 1'b0; wb_valid = 1'b0;
        #1 chk("prerst_count", fifo_count, 3);
        chk("prerst_we3", WE3, 1);
        rst = 1'b1;
        #1 chk("midrst_we3", WE3, 0);
        tick();
        rst = 1'b0;
        #1 chk("postrst_count", fifo_count, 0);
        chk("postrst_pending", pending, 0);
        chk("postrst_ready", mc_ready, 1);
        chk("postrst_we3", WE3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
